// File: rtl/logic_sweep_pkg.sv
// Shared types and helpers for the logic sweep sequencer: FSM states,
// default expected table and row/bit mapping.
package logic_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_e;

  localparam logic [15:0] TRUTH_TABLE_DEFAULT = 16'h9591;
  localparam int          NUM_ROWS            = 16;
  localparam int          ROW_W               = 4;
  localparam int          ERR_W               = 5;

  // Tables are stored MSB-first: row 0 lives in bit 15.
  function automatic logic [3:0] row_to_bit(input logic [3:0] r);
    return 4'd15 - r;
  endfunction

  function automatic logic majority_of(input int ones, input int samples);
    return ones > (samples / 2);
  endfunction

endpackage

// File: rtl/sweep_majority_sampler.sv
// Counts the ones seen on the circuit output while enabled and reports the
// majority decision over the SAMPLES samples taken for the current row.
module sweep_majority_sampler
  import logic_sweep_pkg::*;
#(
  parameter int SAMPLES = 3,
  parameter int CNT_W   = $clog2(SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             dut_out_i,
  output logic [CNT_W-1:0] ones_o,
  output logic             majority_o
);

  logic [CNT_W-1:0] ones_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones_q <= '0;
    end else if (clear_i) begin
      ones_q <= '0;
    end else if (enable_i && dut_out_i) begin
      ones_q <= ones_q + 1'b1;
    end
  end

  assign ones_o     = ones_q;
  assign majority_o = majority_of(int'(ones_q), SAMPLES);

endmodule

// File: rtl/logic_sweep_sequencer.sv
// Sweeps all 16 input rows of a 4-input circuit, majority-votes its output per
// row and compares the assembled truth table with TRUTH_TABLE.
module logic_sweep_sequencer
  import logic_sweep_pkg::*;
#(
  parameter logic [15:0] TRUTH_TABLE   = TRUTH_TABLE_DEFAULT,
  parameter int          SETTLE_CYCLES = 4,
  parameter int          SAMPLES       = 3,
  parameter int          SCNT_W        = $clog2(SAMPLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              in1,
  output logic              in2,
  output logic              in3,
  output logic              in4,
  input  logic              dut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       obs_table,
  output logic [ERR_W-1:0]  err_count,
  output sweep_state_e      state_dbg,
  output logic [SCNT_W-1:0] ones_dbg
);

  localparam int PH_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] SAMPLE_LAST = PH_W'(SAMPLES - 1);

  sweep_state_e     state_q;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] in_q;
  logic [PH_W-1:0]  ph_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [15:0]      obs_q;
  logic [ERR_W-1:0] err_q;

  logic [3:0]       bit_idx;
  logic             maj_bit;
  logic             mismatch;
  logic [ERR_W-1:0] err_d;

  sweep_majority_sampler #(
    .SAMPLES (SAMPLES),
    .CNT_W   (SCNT_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == ST_IDLE || state_q == ST_APPLY),
    .enable_i   (state_q == ST_SAMPLE),
    .dut_out_i  (dut_out),
    .ones_o     (ones_dbg),
    .majority_o (maj_bit)
  );

  assign bit_idx  = row_to_bit(row_q);
  assign mismatch = maj_bit != TRUTH_TABLE[bit_idx];
  assign err_d    = err_q + ERR_W'(mismatch);

  // Host handshake: start is a one-cycle request taken only while busy=0;
  // abort cancels a running sweep (never a DONE cycle); done pulses once per
  // completed sweep, with pass/obs_table/err_count valid from then on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      in_q    <= '0;
      ph_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      obs_q   <= '0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          in_q   <= '0;
          busy_q <= 1'b0;
          if (start) begin
            obs_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            row_q   <= '0;
            ph_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_APPLY;
          end
        end
        ST_APPLY, ST_SAMPLE, ST_COMMIT: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            in_q    <= '0;
            ph_q    <= '0;
          end else if (state_q == ST_APPLY) begin
            if (ph_q == SETTLE_LAST) begin
              ph_q    <= '0;
              state_q <= ST_SAMPLE;
            end else begin
              ph_q <= ph_q + 1'b1;
            end
          end else if (state_q == ST_SAMPLE) begin
            if (ph_q == SAMPLE_LAST) begin
              ph_q    <= '0;
              state_q <= ST_COMMIT;
            end else begin
              ph_q <= ph_q + 1'b1;
            end
          end else begin
            obs_q[bit_idx] <= maj_bit;
            err_q          <= err_d;
            if (row_q == 4'd15) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
              in_q    <= '0;
            end else begin
              row_q   <= row_q + 1'b1;
              in_q    <= row_q + 1'b1;
              state_q <= ST_APPLY;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign {in1, in2, in3, in4} = in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign obs_table = obs_q;
  assign err_count = err_q;
  assign state_dbg = state_q;

endmodule

// File: doc/logic_sweep_sequencer.md
Name: logic_sweep_sequencer

Overview:
- Characterisation controller for a 4-input combinational logic circuit, e.g. a NOR/NOT gate netlist implementing truth table 16'h9591.
- Drives all 16 input combinations into the circuit in order.
- For each row, waits a settle interval, then takes a majority vote over several samples of the circuit output.
- Assembles the observed truth table and compares it against the expected table.
- Sits between a host/test controller (start/abort/done handshake) and the circuit under characterisation.

Parameters:
- TRUTH_TABLE, 16'h9591: expected function. Bit 15 = row 0, bit 0 = row 15 (MSB-first row order).
- SETTLE_CYCLES, 4: cycles each row is held before sampling. Must be ≥1.
- SAMPLES, 3: samples per row. Must be odd and ≥1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a sweep. Ignored while busy=1.
- abort  in  1  cancels a sweep in progress. Ignored in IDLE.
- in1  out  1  circuit input.
- in2  out  1  circuit input.
- in3  out  1  circuit input.
- in4  out  1  circuit input.
- dut_out  in  1  circuit output. Synchronous to clk, or pre-synchronised upstream.
- busy  out  1  high while a sweep is running.
- done  out  1  one-cycle pulse at the end of a completed sweep.
- pass  out  1  observed table == TRUTH_TABLE. Valid from done; held until the next accepted start.
- obs_table  out  16  observed truth table, same bit order as TRUTH_TABLE.
- err_count  out  5  number of mismatching rows, 0..16.

Behaviour:
- Reset: state=IDLE; in1..in4=0, busy=0, done=0, pass=0, obs_table=0, err_count=0. Reset acts immediately, including mid-sweep.
- Row mapping: for row r, in1=r[3], in2=r[2], in3=r[1], in4=r[0]. Expected bit = TRUTH_TABLE[15-r].
- FSM states: IDLE, APPLY, SAMPLE, COMMIT, DONE.
- IDLE:
  - in1..in4=0.
  - When start=1: clear obs_table, err_count and pass; set r=0; go to APPLY.
- APPLY:
  - Drive row r for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE:
  - Row r still driven.
  - Sample dut_out on each of SAMPLES consecutive cycles; count the ones.
  - Count width = clog2(SAMPLES+1).
  - Then go to COMMIT.
- COMMIT (1 cycle):
  - bit = (ones > SAMPLES/2), i.e. majority vote.
  - Write the bit to obs_table[15-r].
  - If the bit differs from TRUTH_TABLE[15-r], increment err_count.
  - If r==15 go to DONE; else r=r+1 and go to APPLY. r wraps only via DONE, never past 15.
- DONE (1 cycle):
  - done=1; pass=(err_count==0); in1..in4=0; go to IDLE.
- busy: high in APPLY, SAMPLE, COMMIT and DONE; low only in IDLE.
- Latency: start registered at edge 0 → APPLY row 0 from cycle 1.
  - Each row takes SETTLE_CYCLES+SAMPLES+1 cycles.
  - done is high in cycle 16*(SETTLE_CYCLES+SAMPLES+1)+1. With defaults this is cycle 129.
- abort:
  - Taking effect in APPLY, SAMPLE or COMMIT: next state IDLE; no done pulse; pass=0; in1..in4=0.
  - obs_table and err_count keep their partial values.
  - abort and start together: abort wins; start is ignored because busy=1.
- start is honoured again in the cycle after done.

Decomposition:
- Shared package logic_sweep_pkg:
  - state enum
  - TRUTH_TABLE default constant
  - function row_to_bit(r) = 15-r
  - localparams for the counter widths
- One sub-module, sweep_majority_sampler:
  - Inputs: clear, enable, dut_out.
  - Outputs: ones count and majority bit.
  - Contains the sample counter.

Test Plan:
1. Ideal gate model of 16'h9591 drives dut_out combinationally, defaults → done in cycle 129; obs_table=16'h9591; err_count=0; pass=1; busy low at cycle 130.
2. dut_out stuck at 0 → obs_table=16'h0000; err_count=7; pass=0.
3. Ideal model, but dut_out inverted for one sample cycle on row 1 (expected 0) → majority rejects the glitch; obs_table=16'h9591; pass=1.
4. Ideal model, but dut_out inverted for all samples on row 5 (obs_table bit 10) → obs_table=16'h9191; err_count=1; pass=0.
5. abort in APPLY of row 8 → next cycle busy=0, in1..in4=0, no done; obs_table bits 15..8 = 8'h95. A fresh start then completes as in scenario 1.
6. rst pulsed asynchronously mid-SAMPLE → all outputs 0 before the next clk edge. A start pulse while busy=1 (second run) is ignored, with no restart of row 0.
